// File: rtl/mm_game_pkg.sv
// Shared types and default constants for the up/down counting game.
package mm_game_pkg;

  localparam int GAME_WIDTH = 4;
  localparam int START_VAL  = 7;
  localparam int MAX_SCORE  = 15;

  typedef enum logic [1:0] {
    UP1 = 2'd0,
    UP2 = 2'd1,
    DN1 = 2'd2,
    DN2 = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'd0,
    WHO_LOSER  = 2'd1,
    WHO_WINNER = 2'd2
  } who_e;

endpackage

// File: rtl/mm_game_counter_if.sv
// Game interface: player controls in, counter/score/result status out.
interface mm_game_counter_if
  import mm_game_pkg::*;
#(
  parameter int WIDTH = GAME_WIDTH
);

  ctrl_e             ctrl;
  logic              init;
  logic [WIDTH-1:0]  init_val;
  logic [WIDTH-1:0]  count;
  logic              winner;
  logic              loser;
  logic [WIDTH-1:0]  w_count;
  logic [WIDTH-1:0]  l_count;
  logic              gameover;
  who_e              who;

  modport master (
    output ctrl, init, init_val,
    input  count, winner, loser, w_count, l_count, gameover, who
  );

  modport slave (
    input  ctrl, init, init_val,
    output count, winner, loser, w_count, l_count, gameover, who
  );

endinterface

// File: rtl/mm_game_score.sv
// Winner/loser score counters and game-over decode; the game-over cycle
// itself is the clear request, so scores drop to zero at its closing edge.
module mm_game_score
  import mm_game_pkg::*;
#(
  parameter int WIDTH     = GAME_WIDTH,
  parameter int MAX_SCORE = mm_game_pkg::MAX_SCORE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winner_i,
  input  logic             loser_i,
  output logic [WIDTH-1:0] w_count_o,
  output logic [WIDTH-1:0] l_count_o,
  output logic             gameover_o,
  output who_e             who_o,
  output logic             clear_o
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_SCORE);

  logic [WIDTH-1:0] w_count_q, w_count_d;
  logic [WIDTH-1:0] l_count_q, l_count_d;
  logic             w_hit, l_hit;

  assign w_hit = (w_count_q == MAX);
  assign l_hit = (l_count_q == MAX);

  always_comb begin
    gameover_o = w_hit | l_hit;
    clear_o    = w_hit | l_hit;
    who_o      = WHO_NONE;
    if (w_hit) begin
      who_o = WHO_WINNER;
    end else if (l_hit) begin
      who_o = WHO_LOSER;
    end
  end

  // Pulses arriving during the game-over cycle are dropped by the clear.
  always_comb begin
    w_count_d = w_count_q;
    l_count_d = l_count_q;
    if (clear_o) begin
      w_count_d = '0;
      l_count_d = '0;
    end else begin
      if (winner_i) w_count_d = w_count_q + WIDTH'(1);
      if (loser_i)  l_count_d = l_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_count_q <= '0;
      l_count_q <= '0;
    end else begin
      w_count_q <= w_count_d;
      l_count_q <= l_count_d;
    end
  end

  assign w_count_o = w_count_q;
  assign l_count_o = l_count_q;

endmodule

// File: rtl/mm_game_counter.sv
// Multi-mode wrapping up/down counter; edges into all-ones/zero pulse
// winner/loser, which feed the score block that ends and restarts the game.
module mm_game_counter
  import mm_game_pkg::*;
#(
  parameter int WIDTH     = GAME_WIDTH,
  parameter int START_VAL = mm_game_pkg::START_VAL,
  parameter int MAX_SCORE = mm_game_pkg::MAX_SCORE
) (
  input  logic         clk,
  input  logic         rst,
  mm_game_counter_if.slave gif
);

  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [WIDTH-1:0] START = WIDTH'(START_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] step_val;
  logic             ones_q, ones_d;
  logic             zero_q, zero_d;
  logic             winner, loser, clear;

  always_comb begin
    step_val = count_q;
    case (gif.ctrl)
      UP1:     step_val = count_q + WIDTH'(1);
      UP2:     step_val = count_q + WIDTH'(2);
      DN1:     step_val = count_q - WIDTH'(1);
      DN2:     step_val = count_q - WIDTH'(2);
      default: step_val = count_q;
    endcase
  end

  // ones_q/zero_q remember whether the previous cycle already sat on a target.
  always_comb begin
    count_d = count_q;
    ones_d  = (count_q == ONES);
    zero_d  = (count_q == '0);
    if (clear) begin
      count_d = START;
      ones_d  = 1'b0;
      zero_d  = 1'b0;
    end else if (gif.init) begin
      count_d = gif.init_val;
    end else begin
      count_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= START;
      ones_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ones_q  <= ones_d;
      zero_q  <= zero_d;
    end
  end

  assign winner = (count_q == ONES) & ~ones_q;
  assign loser  = (count_q == '0)   & ~zero_q;

  mm_game_score #(
    .WIDTH     (WIDTH),
    .MAX_SCORE (MAX_SCORE)
  ) u_score (
    .clk        (clk),
    .rst        (rst),
    .winner_i   (winner),
    .loser_i    (loser),
    .w_count_o  (gif.w_count),
    .l_count_o  (gif.l_count),
    .gameover_o (gif.gameover),
    .who_o      (gif.who),
    .clear_o    (clear)
  );

  assign gif.count  = count_q;
  assign gif.winner = winner;
  assign gif.loser  = loser;

endmodule

// File: tb/tb_mm_game_counter.sv
// Directed game scenarios with a behavioural scoreboard checked every cycle.
module tb_mm_game_counter;
  import mm_game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mm_game_counter_if #(.WIDTH(4)) gif ();

  mm_game_counter #(
    .WIDTH     (4),
    .START_VAL (7),
    .MAX_SCORE (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] count;
    logic       winner;
    logic       loser;
    logic [3:0] w;
    logic [3:0] l;
    logic       go;
    logic [1:0] who;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_count = 4'd0;
  logic [3:0] m_w     = 4'd0;
  logic [3:0] m_l     = 4'd0;
  logic       m_po    = 1'b0;
  logic       m_pz    = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference game model: advance one clock edge and queue the expected outputs.
  task automatic model(input logic r, input logic [1:0] c, input logic in, input logic [3:0] v);
    logic win, los, go;
    exp_t e;
    win = (m_count == 4'd15) && !m_po;
    los = (m_count == 4'd0) && !m_pz;
    go  = (m_w == 4'd15) || (m_l == 4'd15);
    if (r || go) begin
      m_count = 4'd7;
      m_w = 4'd0;
      m_l = 4'd0;
      m_po = 1'b0;
      m_pz = 1'b0;
    end else begin
      if (win) m_w = m_w + 4'd1;
      if (los) m_l = m_l + 4'd1;
      m_po = (m_count == 4'd15);
      m_pz = (m_count == 4'd0);
      if (in) m_count = v;
      else begin
        case (c)
          2'd0:    m_count = m_count + 4'd1;
          2'd1:    m_count = m_count + 4'd2;
          2'd2:    m_count = m_count - 4'd1;
          default: m_count = m_count - 4'd2;
        endcase
      end
    end
    e.count  = m_count;
    e.winner = (m_count == 4'd15) && !m_po;
    e.loser  = (m_count == 4'd0) && !m_pz;
    e.w      = m_w;
    e.l      = m_l;
    e.go     = (m_w == 4'd15) || (m_l == 4'd15);
    e.who    = (m_w == 4'd15) ? 2'd2 : ((m_l == 4'd15) ? 2'd1 : 2'd0);
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [1:0] c, input logic in, input logic [3:0] v);
    exp_t e;
    @(negedge clk);
    rst          = r;
    gif.ctrl     = ctrl_e'(c);
    gif.init     = in;
    gif.init_val = v;
    model(r, c, in, v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_count",    8'(gif.count),    8'(e.count));
      chk("sb_winner",   8'(gif.winner),   8'(e.winner));
      chk("sb_loser",    8'(gif.loser),    8'(e.loser));
      chk("sb_w_count",  8'(gif.w_count),  8'(e.w));
      chk("sb_l_count",  8'(gif.l_count),  8'(e.l));
      chk("sb_gameover", 8'(gif.gameover), 8'(e.go));
      chk("sb_who",      8'(gif.who),      8'(e.who));
    end
  endtask

  initial begin
    int  pulses;
    int  wins;
    int  losses;
    bit  seen;
    logic [3:0] w0;

    gif.ctrl     = UP1;
    gif.init     = 1'b0;
    gif.init_val = 4'd0;

    // Reset held two cycles
    cyc(1'b1, 2'd0, 1'b0, 4'd0);
    cyc(1'b1, 2'd0, 1'b0, 4'd0);
    chk("rst_count",    8'(gif.count),    8'd7);
    chk("rst_w_count",  8'(gif.w_count),  8'd0);
    chk("rst_l_count",  8'(gif.l_count),  8'd0);
    chk("rst_gameover", 8'(gif.gameover), 8'd0);
    chk("rst_who",      8'(gif.who),      8'd0);
    chk("rst_pulse",    8'({gif.winner, gif.loser}), 8'd0);
    cyc(1'b0, 2'd0, 1'b1, 4'd5);
    chk("init_5", 8'(gif.count), 8'd5);

    // Counting modes from 5
    cyc(1'b0, 2'd0, 1'b0, 4'd0);  chk("up1", 8'(gif.count), 8'd6);
    cyc(1'b0, 2'd0, 1'b1, 4'd5);
    cyc(1'b0, 2'd1, 1'b0, 4'd0);  chk("up2_a", 8'(gif.count), 8'd7);
    cyc(1'b0, 2'd1, 1'b0, 4'd0);  chk("up2_b", 8'(gif.count), 8'd9);
    cyc(1'b0, 2'd0, 1'b1, 4'd5);
    cyc(1'b0, 2'd2, 1'b0, 4'd0);  chk("dn1", 8'(gif.count), 8'd4);
    cyc(1'b0, 2'd0, 1'b1, 4'd5);
    cyc(1'b0, 2'd3, 1'b0, 4'd0);  chk("dn2_a", 8'(gif.count), 8'd3);
    cyc(1'b0, 2'd3, 1'b0, 4'd0);  chk("dn2_b", 8'(gif.count), 8'd1);
    cyc(1'b0, 2'd3, 1'b0, 4'd0);  chk("wrap_1m2", 8'(gif.count), 8'd15);
    cyc(1'b0, 2'd0, 1'b1, 4'd14);
    cyc(1'b0, 2'd1, 1'b0, 4'd0);
    chk("wrap_14p2", 8'(gif.count), 8'd0);
    chk("wrap_loser", 8'(gif.loser), 8'd1);

    // Held init at all-ones pulses once
    w0 = gif.w_count;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd0, 1'b1, 4'd15);
      if (gif.winner) pulses++;
    end
    chk("hold_pulses", 8'(pulses), 8'd1);
    chk("hold_w_inc", 8'(gif.w_count), 8'(w0 + 4'd1));

    // Winner game from a clean reset
    cyc(1'b1, 2'd0, 1'b0, 4'd0);
    wins = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 4'd0);
      if (gif.gameover) seen = 1'b1;
      else if (gif.winner) wins++;
    end
    chk("win_game_done", 8'(seen), 8'd1);
    chk("win_pulses", 8'(wins), 8'd15);
    chk("win_who", 8'(gif.who), 8'd2);
    cyc(1'b0, 2'd0, 1'b0, 4'd0);
    chk("win_clr_go", 8'(gif.gameover), 8'd0);
    chk("win_clr_who", 8'(gif.who), 8'd0);
    chk("win_clr_count", 8'(gif.count), 8'd7);
    chk("win_clr_scores", 8'({gif.w_count, gif.l_count}), 8'd0);

    // Loser game continues without reset: even values only under down-by-2
    cyc(1'b0, 2'd2, 1'b0, 4'd0);
    losses = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(1'b0, 2'd3, 1'b0, 4'd0);
      if (gif.gameover) seen = 1'b1;
      else if (gif.loser) losses++;
    end
    chk("lose_game_done", 8'(seen), 8'd1);
    chk("lose_pulses", 8'(losses), 8'd15);
    chk("lose_who", 8'(gif.who), 8'd1);
    cyc(1'b0, 2'd3, 1'b0, 4'd0);
    chk("lose_clr_count", 8'(gif.count), 8'd7);
    chk("lose_clr_scores", 8'({gif.w_count, gif.l_count}), 8'd0);
    cyc(1'b0, 2'd0, 1'b0, 4'd0);
    chk("play_on", 8'(gif.count), 8'd8);

    // Reset mid-game at nine wins
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc(1'b0, 2'd0, 1'b1, (i % 2 == 0) ? 4'd15 : 4'd14);
      if (gif.w_count == 4'd9) seen = 1'b1;
    end
    chk("mid_reach_9", 8'(seen), 8'd1);
    cyc(1'b1, 2'd0, 1'b0, 4'd0);
    chk("mid_rst_count", 8'(gif.count), 8'd7);
    chk("mid_rst_scores", 8'({gif.w_count, gif.l_count}), 8'd0);
    chk("mid_rst_go", 8'(gif.gameover), 8'd0);
    cyc(1'b0, 2'd0, 1'b0, 4'd0);
    chk("mid_after_go", 8'(gif.gameover), 8'd0);

    // init during the game-over cycle is ignored
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cyc(1'b0, 2'd0, 1'b1, (i % 2 == 0) ? 4'd15 : 4'd14);
      if (gif.gameover) seen = 1'b1;
    end
    chk("ign_game_done", 8'(seen), 8'd1);
    cyc(1'b0, 2'd0, 1'b1, 4'd3);
    chk("ign_init_count", 8'(gif.count), 8'd7);
    chk("ign_init_w", 8'(gif.w_count), 8'd0);
    cyc(1'b0, 2'd0, 1'b1, 4'd3);
    chk("init_after", 8'(gif.count), 8'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
